// File: rtl/spu_alu_pkg.sv
// Shared definitions for the SPU sequential ALU: opcode map, flag bit
// positions and control FSM states.
package spu_alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_NOTA = 6'd5;
  localparam logic [5:0] OP_SHL  = 6'd6;
  localparam logic [5:0] OP_SHR  = 6'd7;
  localparam logic [5:0] OP_SRA  = 6'd8;
  localparam logic [5:0] OP_SLT  = 6'd9;
  localparam logic [5:0] OP_MUL  = 6'd10;
  localparam logic [5:0] OP_MULH = 6'd11;
  localparam logic [5:0] OP_SADD = 6'd12;
  localparam logic [5:0] OP_SSUB = 6'd13;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_OUT_HOLD
  } state_e;

endpackage

// File: rtl/spu_alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// product_o is the value after the current step, so it is final while done_o is high.
module spu_alu_mul_iter #(
  parameter int unsigned dataWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [dataWidth-1:0]     a_i,
  input  logic [dataWidth-1:0]     b_i,
  output logic                     done_o,
  output logic [2*dataWidth-1:0]   product_o
);

  localparam int unsigned CW = $clog2(dataWidth);

  logic                   busy_q;
  logic [CW-1:0]          cnt_q;
  logic [dataWidth-1:0]   mcand_q;
  logic [2*dataWidth-1:0] prod_q, prod_d;
  logic [dataWidth:0]     partial;

  // Upper half accumulates; the multiplier drains out of the lower half.
  always_comb begin
    partial = {1'b0, prod_q[2*dataWidth-1:dataWidth]}
            + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d  = {partial, prod_q[dataWidth-1:1]};
  end

  assign done_o    = busy_q && (cnt_q == CW'(dataWidth - 1));
  assign product_o = prod_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      mcand_q <= a_i;
      prod_q  <= {{dataWidth{1'b0}}, b_i};
    end else if (busy_q) begin
      prod_q <= prod_d;
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/spu_alu_seq.sv
// Handshaked multi-cycle ALU with registered result and {N,V,C,Z} flags.
// Define SPU_ALU_SAT_EN to enable signed saturating add/sub (opcodes 12/13).
module spu_alu_seq
  import spu_alu_pkg::*;
#(
  parameter int unsigned dataWidth = 8
) (
  input  logic                 clk_fake,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           opCode,
  input  logic [dataWidth-1:0] inA,
  input  logic [dataWidth-1:0] inB,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [dataWidth-1:0] dataOut,
  output logic [3:0]           flags,
  output logic                 err
);

  localparam int unsigned SW  = $clog2(dataWidth);
  localparam int unsigned MSB = dataWidth - 1;
`ifdef SPU_ALU_SAT_EN
  localparam logic [dataWidth-1:0] SMAX = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic [dataWidth-1:0] SMIN = ~SMAX;
`endif

  state_e                 state_q, state_d;
  logic [dataWidth-1:0]   data_q, data_d;
  logic [3:0]             flags_q, flags_d;
  logic                   err_q, err_d;
  logic                   mulh_q, mulh_d;

  logic                   accept, is_mul, mul_done;
  logic [2*dataWidth-1:0] mul_prod;
  logic [dataWidth-1:0]   mul_res, alu_res;
  logic [3:0]             mul_flags, alu_flags;
  logic                   alu_err, alu_c, alu_v;
  logic [dataWidth:0]     sum;
  logic [SW-1:0]          sh;

  assign out_valid = (state_q == ST_OUT_HOLD);
  assign in_ready  = !rst && (state_q != ST_MUL) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (opCode == OP_MUL) || (opCode == OP_MULH);

  spu_alu_mul_iter #(.dataWidth(dataWidth)) u_mul (
    .clk_i     (clk_fake),
    .rst_i     (rst),
    .start_i   (accept && is_mul),
    .a_i       (inA),
    .b_i       (inB),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    sh      = inB[SW-1:0];
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (opCode)
      OP_ADD: begin
        sum     = {1'b0, inA} + {1'b0, inB};
        alu_res = sum[MSB:0];
        alu_c   = sum[dataWidth];
        alu_v   = (inA[MSB] == inB[MSB]) && (alu_res[MSB] != inA[MSB]);
      end
      OP_SUB: begin
        alu_res = inA - inB;
        alu_c   = inA < inB;
        alu_v   = (inA[MSB] != inB[MSB]) && (alu_res[MSB] != inA[MSB]);
      end
      OP_AND:  alu_res = inA & inB;
      OP_OR:   alu_res = inA | inB;
      OP_XOR:  alu_res = inA ^ inB;
      OP_NOTA: alu_res = ~inA;
      OP_SHL: begin
        alu_res = inA << sh;
        alu_c   = (sh != '0) && inA[SW'(dataWidth - 32'(sh))];
      end
      OP_SHR: begin
        alu_res = inA >> sh;
        alu_c   = (sh != '0) && inA[sh - SW'(1)];
      end
      OP_SRA: begin
        alu_res = $signed(inA) >>> sh;
        alu_c   = (sh != '0) && inA[sh - SW'(1)];
      end
      OP_SLT:  alu_res = {{(dataWidth-1){1'b0}}, $signed(inA) < $signed(inB)};
      OP_MUL, OP_MULH: ;
`ifdef SPU_ALU_SAT_EN
      OP_SADD, OP_SSUB: begin
        if (opCode == OP_SADD) begin
          alu_res = inA + inB;
          alu_v   = (inA[MSB] == inB[MSB]) && (alu_res[MSB] != inA[MSB]);
        end else begin
          alu_res = inA - inB;
          alu_v   = (inA[MSB] != inB[MSB]) && (alu_res[MSB] != inA[MSB]);
        end
        // Overflow direction always follows the sign of inA.
        if (alu_v) alu_res = inA[MSB] ? SMIN : SMAX;
      end
`endif
      default: alu_err = 1'b1;
    endcase

    alu_flags = '0;
    if (!alu_err) begin
      alu_flags[FLAG_N] = alu_res[MSB];
      alu_flags[FLAG_V] = alu_v;
      alu_flags[FLAG_C] = alu_c;
      alu_flags[FLAG_Z] = (alu_res == '0);
    end
  end

  always_comb begin
    mul_res           = mulh_q ? mul_prod[2*dataWidth-1:dataWidth] : mul_prod[MSB:0];
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_res[MSB];
    mul_flags[FLAG_V] = |mul_prod[2*dataWidth-1:dataWidth];
    mul_flags[FLAG_Z] = (mul_res == '0);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    flags_d = flags_q;
    err_d   = err_q;
    mulh_d  = mulh_q;
    case (state_q)
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_OUT_HOLD;
          data_d  = mul_res;
          flags_d = mul_flags;
          err_d   = 1'b0;
        end
      end
      default: begin
        if ((state_q == ST_OUT_HOLD) && out_ready) state_d = ST_IDLE;
        if (accept) begin
          if (is_mul) begin
            state_d = ST_MUL;
            mulh_d  = (opCode == OP_MULH);
          end else begin
            state_d = ST_OUT_HOLD;
            data_d  = alu_res;
            flags_d = alu_flags;
            err_d   = alu_err;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_fake) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      mulh_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      mulh_q  <= mulh_d;
    end
  end

  assign dataOut = data_q;
  assign flags   = flags_q;
  assign err     = err_q;

endmodule

// File: tb/tb_spu_alu_seq.sv
// Bench for spu_alu_seq: directed timing/corner cases plus randomized traffic
// against an integer-arithmetic reference model and an in-order scoreboard.
module tb_spu_alu_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic [3:0]   f;
    logic         e;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   opCode = '0;
  logic [W-1:0] inA = '0;
  logic [W-1:0] inB = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] dataOut;
  logic [3:0]   flags;
  logic         err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  res_t exp_q[$];

  spu_alu_seq #(.dataWidth(W)) dut (
    .clk_fake  (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opCode    (opCode),
    .inA       (inA),
    .inB       (inB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataOut   (dataOut),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input int op, input int a, input int b);
    int   m    = (1 << W) - 1;
    int   half = 1 << (W - 1);
    int   sa   = (a >= half) ? a - (1 << W) : a;
    int   sb   = (b >= half) ? b - (1 << W) : b;
    int   sh   = b % W;
    int   r = 0, c = 0, v = 0, e = 0, s;
    int   p    = a * b;
    res_t res;
    case (op)
      0:  begin r = a + b; c = int'(r > m); s = sa + sb; v = int'(s > half - 1 || s < -half); end
      1:  begin r = a - b; c = int'(a < b); s = sa - sb; v = int'(s > half - 1 || s < -half); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~a;
      6:  begin r = a << sh; c = (sh != 0) ? (a >> (W - sh)) & 1 : 0; end
      7:  begin r = a >> sh; c = (sh != 0) ? (a >> (sh - 1)) & 1 : 0; end
      8:  begin r = sa >>> sh; c = (sh != 0) ? (a >> (sh - 1)) & 1 : 0; end
      9:  r = int'(sa < sb);
      10: begin r = p; v = int'((p >> W) != 0); end
      11: begin r = p >> W; v = int'((p >> W) != 0); end
`ifdef SPU_ALU_SAT_EN
      12, 13: begin
        s = (op == 12) ? sa + sb : sa - sb;
        if (s > half - 1) begin s = half - 1; v = 1; end
        if (s < -half)    begin s = -half;    v = 1; end
        r = s;
      end
`endif
      default: e = 1;
    endcase
    r = r & m;
    if (e != 0) begin
      res.d = '0;
      res.f = '0;
      res.e = 1'b1;
    end else begin
      res.d = r[W-1:0];
      res.f = {r >= half, v[0], c[0], r == 0};
      res.e = 1'b0;
    end
    return res;
  endfunction

  // Scoreboard: push on every accepted op, pop on every taken result.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          check("mon_data",  32'(dataOut), 32'(exp_q[0].d));
          check("mon_flags", 32'(flags),   32'(exp_q[0].f));
          check("mon_err",   32'(err),     32'(exp_q[0].e));
          if (!out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
          else void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(opCode), int'(inA), int'(inB)));
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic ok = 1'b0;
    in_valid = 1'b1;
    opCode   = op;
    inA      = a;
    inB      = b;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    opCode   = 6'($urandom);
    inA      = W'($urandom);
    inB      = W'($urandom);
  endtask

  task automatic run_op(input string tag, input int op, input int a, input int b,
                        input int ed, input int ef, input int ee, input int el, input int elow);
    int lat = 0;
    int low = 0;
    send(6'(op), W'(a), W'(b));
    idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (!in_ready) low++;
      if (out_valid) break;
    end
    check({tag, "_latency"},  32'(lat), 32'(el));
    check({tag, "_ready_low"}, 32'(low), 32'(elow));
    check({tag, "_data"},  32'(dataOut), 32'(ed));
    check({tag, "_flags"}, 32'(flags),   32'(ef));
    check({tag, "_err"},   32'(err),     32'(ee));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] rand_op();
    return ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 13));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  t0, t1, seen;
    logic done;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data",      32'(dataOut),   32'd0);
    check("rst_flags",     32'(flags),     32'd0);
    check("rst_err",       32'(err),       32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed cases; flags are {N,V,C,Z}
    run_op("add_12_10",  0, 8'd12, 8'd10, 8'd22, 4'b0000, 0, 1, 0);
    run_op("sub_10_12",  1, 8'd10, 8'd12, 8'hFE, 4'b1010, 0, 1, 0);
    run_op("add_7f_01",  0, 8'h7F, 8'h01, 8'h80, 4'b1100, 0, 1, 0);
    run_op("add_ff_01",  0, 8'hFF, 8'h01, 8'h00, 4'b0011, 0, 1, 0);
    run_op("mul_12_10", 10, 8'd12, 8'd10, 8'd120, 4'b0000, 0, W + 1, W);
    run_op("mulh_ff_ff", 11, 8'hFF, 8'hFF, 8'hFE, 4'b1100, 0, W + 1, W);
    run_op("shl_81_9",   6, 8'h81, 8'h09, 8'h02, 4'b0010, 0, 1, 0);
    run_op("shr_by_0",   7, 8'h81, 8'h08, 8'h81, 4'b1000, 0, 1, 0);
    run_op("illegal_63", 63, 8'h55, 8'h33, 8'h00, 4'b0000, 1, 1, 0);
`ifdef SPU_ALU_SAT_EN
    run_op("sadd_70_20", 12, 8'h70, 8'h20, 8'h7F, 4'b0100, 0, 1, 0);
    run_op("ssub_80_01", 13, 8'h80, 8'h01, 8'h80, 4'b1100, 0, 1, 0);
`else
    run_op("sadd_70_20", 12, 8'h70, 8'h20, 8'h00, 4'b0000, 1, 1, 0);
`endif

    // Back-to-back simple ops: one accept per cycle
    send(6'd0, 8'd1, 8'd2);
    t0 = cyc;
    send(6'd4, 8'hF0, 8'h0F);
    send(6'd9, 8'h80, 8'h01);
    send(6'd8, 8'h80, 8'h03);
    t1 = cyc;
    idle();
    check("throughput_cycles", 32'(t1 - t0), 32'd3);
    repeat (3) @(posedge clk);
    #1;

    // Stall: result frozen, in_ready low, then in-order drain
    out_ready = 1'b0;
    send(6'd0, 8'd3, 8'd4);
    in_valid = 1'b1;
    opCode   = 6'd1;
    inA      = 8'd9;
    inB      = 8'd2;
    repeat (4) begin
      @(negedge clk);
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready),  32'd0);
      check("hold_data",     32'(dataOut),   32'd7);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(6'd1, 8'd9, 8'd2);
    send(6'd4, 8'hAA, 8'h0F);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("hold_drained", 32'(exp_q.size()), 32'd0);

    // Reset during the 4th multiply cycle aborts the op
    send(6'd10, 8'd5, 8'd7);
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_data",      32'(dataOut),   32'd0);
    check("abort_flags",     32'(flags),     32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
          send(rand_op(), W'($urandom), W'($urandom));
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spu_alu_seq.md
# spu_alu_seq

Multi-cycle, handshaked, width-parametrised ALU for the SPU datapath. It accepts one operation per valid/ready transfer and returns a registered result with status flags. Single-cycle ops sustain one result per cycle; multiplies run on an iterative shift-add unit. It sits between the operand-fetch stage and writeback, replacing the flat combinational ALU where back-pressure and flags are needed.

## Interface
- dataWidth, 8, operand/result width; ≥4, power of two
- clk_fake  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- opCode  in  6  operation select (package encoding)
- inA, inB  in  dataWidth  operands, sampled on accept
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result when out_valid && out_ready
- dataOut  out  dataWidth  result
- flags  out  4  {N,V,C,Z}, qualified by out_valid
- err  out  1  illegal opcode, qualified by out_valid

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOTA, 6 SHL, 7 SHR (logical), 8 SRA, 9 SLT (signed, result 0/1), 10 MUL (low half, unsigned), 11 MULH (high half, unsigned), 12 SADD, 13 SSUB (see Configuration). All other codes are illegal: dataOut=0, flags=0, err=1, single-cycle.
- Shift amount is inB[$clog2(dataWidth)-1:0]; upper bits are ignored.
- Z = (dataOut==0); N = dataOut MSB.
- C: ADD carry-out; SUB borrow (inA<inB unsigned); shifts give the last bit shifted out (0 for shift-by-0); otherwise 0.
- V: ADD/SUB signed overflow; MUL sets V = (high half ≠ 0); otherwise 0.
- FSM states: IDLE (accepting), MUL (iterating, counter 0..dataWidth-1), OUT_HOLD (result stalled, out_ready low).
- in_ready = !rst && state≠MUL && (!out_valid || out_ready).
- Accepting MUL/MULH moves to MUL and loads the multiplier. When the counter hits dataWidth-1, the result is written and out_valid goes high.

## Timing
- Reset values: in_ready=0 while rst is high, 1 the cycle after; out_valid=0, dataOut=0, flags=0, err=0; state IDLE; counter 0.
- Simple/illegal op accepted at edge N → out_valid high from edge N+1.
- MUL/MULH accepted at edge N → out_valid high from edge N+dataWidth+1 (9 for width 8). in_ready is low for dataWidth cycles.
- Back-to-back: with out_ready high, a new op is accepted in the same cycle the previous result is taken, so throughput is 1/cycle for simple ops.
- out_valid && !out_ready: dataOut, flags and err are frozen, and in_ready is low.
- rst during MUL or OUT_HOLD: the op is aborted and no result is emitted; outputs return to reset values at the next edge.
- Operand changes after accept have no effect.

## Configuration
- SPU_ALU_SAT_EN defined: opcodes 12/13 perform signed saturating add/sub, clamping to 2^(W-1)-1 or -2^(W-1). V=1 when clamped. Single-cycle.
- Not defined: 12/13 are illegal (err=1, dataOut=0). No saturation logic is synthesised.

## Structure
- Package spu_alu_pkg holds the opcode constants (6-bit), flag bit indices (Z=0, C=1, V=2, N=3) and the FSM state enum.
- Sub-module spu_alu_mul_iter is an iterative shift-add unsigned multiplier with start/done and a 2·dataWidth product. The top selects the low or high half.

## Test plan
- ADD 12+10 (width 8) → dataOut=22, flags=0, out_valid one cycle after accept. SUB 10−12 → 0xFE, N=1, C=1.
- ADD 0x7F+0x01 → 0x80, N=1, V=1. ADD 0xFF+0x01 → 0x00, Z=1, C=1.
- MUL 12×10 → 120, out_valid 9 cycles after accept, in_ready low for 8 cycles. MULH 0xFF×0xFF → 0xFE.
- Hold out_ready low over three results → first result is frozen and in_ready stays low. Releasing it delivers the results in order with no loss or duplication.
- Assert rst on the 4th MUL cycle → no out_valid pulse, in_ready=1 after rst drops. SHL 0x81 by inB=0x09 (amount 1) → 0x02, C=1.
- opCode 63 → err=1, dataOut=0. SADD 0x70+0x20: with SPU_ALU_SAT_EN → 0x7F, V=1; without → err=1.
